test_pattern_gen: RTL and testbench

Parametrised test-data source that supersedes the fixed free-running `test` data block. It produces a paced stream of test words in one of four selectable patterns, with a bounded or continuous burst length. Output uses a valid/ready handshake with per-word rate control. It drives interface-board datapaths (FIFO, serialiser, UART) during bring-up and simulation from the 50 MHz system clock.

---
 rtl/test_pattern_gen.sv | 149 ++++++++++++++
 tb/tb_test_pattern_gen.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/test_pattern_gen.sv
// Paced test-data source: emits counter, LFSR, walking-one or alternating
// words over a valid/ready handshake, with a bounded or continuous burst.
module test_pattern_gen #(
    parameter int                DATA_W = 16,
    parameter int                DIV_W  = 16,
    parameter int                LEN_W  = 16,
    parameter logic [DATA_W-1:0] TAPS   = 16'hB400
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] seed,
    input  logic [DIV_W-1:0]  div,
    input  logic [LEN_W-1:0]  len,
    input  logic              ready,
    output logic [DATA_W-1:0] data,
    output logic              valid,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state_reg,  state_next;
    logic [DATA_W-1:0] data_reg,   data_next;
    logic [LEN_W-1:0]  count_reg,  count_next;
    logic [DIV_W-1:0]  pace_reg,   pace_next;
    logic [1:0]        mode_reg,   mode_next;
    logic [DIV_W-1:0]  div_reg,    div_next;
    logic [LEN_W-1:0]  len_reg,    len_next;

    // Successor of a word under the selected pattern.
    function automatic logic [DATA_W-1:0] next_word(input logic [1:0] m,
                                                     input logic [DATA_W-1:0] d);
        logic [DATA_W-1:0] w;
        case (m)
            2'd0:    w = d + DATA_W'(1);
            2'd1:    w = (d >> 1) ^ (d[0] ? TAPS : '0);
            2'd2:    w = {d[DATA_W-2:0], d[DATA_W-1]};
            default: w = ~d;
        endcase
        return w;
    endfunction

    // First word of a burst; an all-zero seed would lock up LFSR and
    // walking-one patterns, so it is replaced with a live value.
    function automatic logic [DATA_W-1:0] first_word(input logic [1:0] m,
                                                      input logic [DATA_W-1:0] s);
        logic [DATA_W-1:0] w;
        w = s;
        if (s == '0) begin
            if (m == 2'd1)
                w = '1;
            else if (m == 2'd2)
                w = DATA_W'(1);
        end
        return w;
    endfunction

    // State and datapath registers; reset aborts any burst without done.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            data_reg  <= '0;
            count_reg <= '0;
            pace_reg  <= '0;
            mode_reg  <= '0;
            div_reg   <= '0;
            len_reg   <= '0;
        end else begin
            state_reg <= state_next;
            data_reg  <= data_next;
            count_reg <= count_next;
            pace_reg  <= pace_next;
            mode_reg  <= mode_next;
            div_reg   <= div_next;
            len_reg   <= len_next;
        end
    end

    // Next-state logic: start latches the burst setup, handshakes advance
    // the word, and the pacing counter runs down through zero so that the
    // next valid rises div+1 cycles after the accepting edge.
    always_comb begin
        state_next = state_reg;
        data_next  = data_reg;
        count_next = count_reg;
        pace_next  = pace_reg;
        mode_next  = mode_reg;
        div_next   = div_reg;
        len_next   = len_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    mode_next  = mode;
                    div_next   = div;
                    len_next   = len;
                    count_next = '0;
                    pace_next  = '0;
                    data_next  = first_word(mode, seed);
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (ready)
                    count_next = count_reg + LEN_W'(1);
                if (stop) begin
                    // Stop wins over a coincident handshake: the word is
                    // delivered but the burst ends without done.
                    state_next = IDLE;
                end else if (ready) begin
                    if (len_reg != '0 && count_next == len_reg) begin
                        state_next = DONE;
                    end else begin
                        data_next = next_word(mode_reg, data_reg);
                        if (div_reg != '0) begin
                            pace_next  = div_reg;
                            state_next = RUN;
                        end
                    end
                end
            end
            RUN: begin
                if (stop)
                    state_next = IDLE;
                else if (pace_reg == '0)
                    state_next = HOLD;
                else
                    pace_next = pace_reg - DIV_W'(1);
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign data  = data_reg;
    assign valid = (state_reg == HOLD);
    assign busy  = (state_reg != IDLE);
    assign done  = (state_reg == DONE);

endmodule

// File: tb/tb_test_pattern_gen.sv
// Scoreboard bench for test_pattern_gen: stimulus queues expected words,
// an independent monitor pops and compares on every handshake.
module tb_test_pattern_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [15:0] seed = 16'h0;
    logic [15:0] div = 16'h0;
    logic [15:0] len = 16'h0;
    logic        ready = 1'b0;
    logic [15:0] data;
    logic        valid;
    logic        busy;
    logic        done;

    test_pattern_gen #(
        .DATA_W(16), .DIV_W(16), .LEN_W(16), .TAPS(16'hB400)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
        .seed(seed), .div(div), .len(len), .ready(ready),
        .data(data), .valid(valid), .busy(busy), .done(done)
    );

    always #10 clk = ~clk;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [15:0] exp_q[$];
    int          done_cnt = 0;
    int          hs_count = 0;
    int          cyc = 0;
    int          exp_gap = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: samples on the falling edge what the next rising edge will see.
    initial begin
        logic        prev_valid;
        logic        prev_stall;
        logic [15:0] held;
        logic [15:0] e;
        int          last_hs;
        prev_valid = 1'b0;
        prev_stall = 1'b0;
        held = '0;
        last_hs = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_valid = 1'b0;
                prev_stall = 1'b0;
            end else begin
                if (valid && prev_stall)
                    check("hold_stable", {16'h0, data}, {16'h0, held});
                if (valid && !prev_valid && exp_gap != 0 && hs_count > 0)
                    check("pace_gap", cyc - last_hs, exp_gap);
                if (valid && ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_word: got %h expected none", data);
                    end else begin
                        e = exp_q.pop_front();
                        check("word", {16'h0, data}, {16'h0, e});
                    end
                    last_hs = cyc + 1;
                    hs_count++;
                end
                if (done)
                    done_cnt++;
                prev_stall = valid && !ready;
                held = data;
                prev_valid = valid;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic do_start(input logic [1:0] m, input logic [15:0] s,
                            input logic [15:0] d, input logic [15:0] l);
        mode = m;
        seed = s;
        div = d;
        len = l;
        hs_count = 0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("start_valid", {31'h0, valid}, 32'd1);
        check("start_busy", {31'h0, busy}, 32'd1);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("reach_idle", {31'h0, busy}, 32'd0);
    endtask

    task automatic wait_hs(input int count, input int budget);
        int n;
        n = 0;
        while (hs_count < count && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("hs_reached", hs_count, count);
    endtask

    initial begin
        int d0;
        // Reset state
        #5 rst = 1'b0;
        #5;
        check("rst_data", {16'h0, data}, 32'h0);
        check("rst_valid", {31'h0, valid}, 32'd0);
        check("rst_busy", {31'h0, busy}, 32'd0);
        check("rst_done", {31'h0, done}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;

        // 1: counter bounded burst with wrap
        ready = 1'b1;
        d0 = done_cnt;
        exp_q.push_back(16'hFFFE);
        exp_q.push_back(16'hFFFF);
        exp_q.push_back(16'h0000);
        do_start(2'd0, 16'hFFFE, 16'd0, 16'd3);
        wait_idle(20);
        check("t1_done_once", done_cnt - d0, 1);
        check("t1_queue_empty", exp_q.size(), 0);
        check("t1_data_hold", {16'h0, data}, 32'h0000);

        // 2: LFSR from seed 1, then zero-seed fix-up
        d0 = done_cnt;
        exp_q.push_back(16'h0001);
        exp_q.push_back(16'hB400);
        exp_q.push_back(16'h5A00);
        exp_q.push_back(16'h2D00);
        do_start(2'd1, 16'h0001, 16'd0, 16'd4);
        wait_idle(20);
        check("t2_done_once", done_cnt - d0, 1);
        d0 = done_cnt;
        exp_q.push_back(16'hFFFF);
        exp_q.push_back(16'h7FFF ^ 16'hB400);
        do_start(2'd1, 16'h0000, 16'd0, 16'd2);
        wait_idle(20);
        check("t2b_done_once", done_cnt - d0, 1);
        check("t2_queue_empty", exp_q.size(), 0);

        // 3: walking one, pacing div=2, backpressure on word 2
        d0 = done_cnt;
        exp_gap = 3;
        exp_q.push_back(16'h0001);
        exp_q.push_back(16'h0002);
        exp_q.push_back(16'h0004);
        exp_q.push_back(16'h0008);
        do_start(2'd2, 16'h0000, 16'd2, 16'd4);
        wait_hs(1, 20);
        ready = 1'b0;
        for (int n = 0; n < 20 && !valid; n++) begin
            @(posedge clk);
            #1;
        end
        check("t3_word2_valid", {31'h0, valid}, 32'd1);
        repeat (5) @(posedge clk);
        #1 ready = 1'b1;
        wait_idle(40);
        exp_gap = 0;
        check("t3_done_once", done_cnt - d0, 1);
        check("t3_queue_empty", exp_q.size(), 0);

        // 4: continuous alternate, stop together with 10th handshake
        d0 = done_cnt;
        for (int i = 0; i < 10; i++)
            exp_q.push_back((i % 2 == 0) ? 16'hA5A5 : 16'h5A5A);
        do_start(2'd3, 16'hA5A5, 16'd0, 16'd0);
        wait_hs(9, 40);
        stop = 1'b1;
        @(posedge clk);
        #1 stop = 1'b0;
        check("t4_valid_low", {31'h0, valid}, 32'd0);
        check("t4_busy_low", {31'h0, busy}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("t4_no_done", done_cnt - d0, 0);
        check("t4_hs_count", hs_count, 10);
        check("t4_queue_empty", exp_q.size(), 0);

        // 6: start while busy is ignored
        d0 = done_cnt;
        exp_gap = 2;
        for (int i = 0; i < 5; i++)
            exp_q.push_back(16'h0100 + 16'(i));
        do_start(2'd0, 16'h0100, 16'd1, 16'd5);
        wait_hs(1, 20);
        seed = 16'h7777;
        mode = 2'd3;
        div = 16'd0;
        len = 16'd1;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_idle(60);
        exp_gap = 0;
        check("t6_done_once", done_cnt - d0, 1);
        check("t6_queue_empty", exp_q.size(), 0);
        check("t6_last_word", {16'h0, data}, 32'h0104);

        // 5: asynchronous reset mid-burst, then restart
        ready = 1'b0;
        d0 = done_cnt;
        do_start(2'd0, 16'h1234, 16'd0, 16'd0);
        check("t5_first_word", {16'h0, data}, 32'h1234);
        repeat (3) @(posedge clk);
        #6 rst = 1'b0;
        #1;
        check("t5_rst_data", {16'h0, data}, 32'h0);
        check("t5_rst_valid", {31'h0, valid}, 32'd0);
        check("t5_rst_busy", {31'h0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        ready = 1'b1;
        exp_q.push_back(16'h0042);
        exp_q.push_back(16'h0043);
        do_start(2'd0, 16'h0042, 16'd0, 16'd2);
        wait_idle(20);
        check("t5_done_once", done_cnt - d0, 1);
        check("t5_queue_empty", exp_q.size(), 0);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
